fetch_prefetch_queue: RTL

//   Instruction-fetch front end that sits directly upstream of STAGE1 (decode).

---
 rtl/fetch_prefetch_queue.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding imem reads
// and queues {pc, instr} pairs for decode; redirects flush the queue and restart fetch.
module fetch_prefetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_W-1:0]       imem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [PC_W-1:0]     fetch_pc_r, fetch_pc_s;
  logic                imem_req_r, imem_req_s;
  logic [PC_W-1:0]     imem_addr_r, imem_addr_s;
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [PC_W-1:0]     pc_mem_r    [DEPTH];
  logic [INSTR_W-1:0]  instr_mem_r [DEPTH];
  logic                push_s, pop_s, flush_s;

  assign imem_req  = imem_req_r;
  assign imem_addr = imem_addr_r;
  assign out_valid = (count_r != {CNT_W{1'b0}});
  assign out_instr = instr_mem_r[rd_ptr_r];
  assign out_pc    = pc_mem_r[rd_ptr_r];
  assign count     = count_r;

  // Fetch FSM next state, request control and queue push/pop/flush decode
  always_comb begin
    state_s     = state_r;
    fetch_pc_s  = fetch_pc_r;
    imem_req_s  = imem_req_r;
    imem_addr_s = imem_addr_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    flush_s     = 1'b0;
    if (redirect) begin
      flush_s    = 1'b1;
      fetch_pc_s = redirect_pc;
      case (state_r)
        S_IDLE: state_s = S_IDLE;
        // An in-flight request cannot be withdrawn; its data is dropped on return.
        S_WAIT, S_DROP: begin
          if (imem_ack) begin
            state_s    = S_IDLE;
            imem_req_s = 1'b0;
          end else begin
            state_s    = S_DROP;
          end
        end
        default: begin
          state_s    = S_IDLE;
          imem_req_s = 1'b0;
        end
      endcase
    end else begin
      pop_s = out_valid && out_ready;
      case (state_r)
        S_IDLE: begin
          if (count_r < CNT_W'(DEPTH)) begin
            imem_req_s  = 1'b1;
            imem_addr_s = fetch_pc_r;
            state_s     = S_WAIT;
          end else begin
            state_s     = S_IDLE;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            push_s     = 1'b1;
            fetch_pc_s = imem_addr_r + PC_W'(1);
            imem_req_s = 1'b0;
            state_s    = S_IDLE;
          end else begin
            state_s    = S_WAIT;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            imem_req_s = 1'b0;
            state_s    = S_IDLE;
          end else begin
            state_s    = S_DROP;
          end
        end
        default: begin
          state_s    = S_IDLE;
          imem_req_s = 1'b0;
        end
      endcase
    end
  end

  // State, request registers and FIFO storage/pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      fetch_pc_r  <= {PC_W{1'b0}};
      imem_req_r  <= 1'b0;
      imem_addr_r <= {PC_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {PC_W{1'b0}};
        instr_mem_r[i] <= {INSTR_W{1'b0}};
      end
    end else begin
      state_r     <= state_s;
      fetch_pc_r  <= fetch_pc_s;
      imem_req_r  <= imem_req_s;
      imem_addr_r <= imem_addr_s;
      if (flush_s) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (push_s) begin
          pc_mem_r[wr_ptr_r]    <= imem_addr_r;
          instr_mem_r[wr_ptr_r] <= imem_data;
          wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule
